// File: rtl/calc.sv
// Single-cycle 32-bit register-machine calculator: internal instruction ROM, 16x32 register file, PC.
// Optional multiplier for op 4 is enabled by defining CALC_MUL_EN.

module calc_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  // Program-counter register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 32'd0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end
endmodule

module calc_imem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  // Contents are loaded externally; the core only ever reads this array.
  logic [31:0] mem [0:DEPTH-1];

  assign data = mem[addr];
endmodule

module calc_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rs_addr,
  input  logic [3:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data
);
  logic [31:0] regs [0:15];

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  // Register write-back; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (we && (wr_addr != 4'd0)) begin
      regs[wr_addr] <= wr_data;
    end else begin
      regs[wr_addr] <= regs[wr_addr];
    end
  end
endmodule

module calc #(
  parameter int IMEM_DEPTH = 1024
) (
  input logic clk,
  input logic reset
);
  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic        halted;
  logic [31:0] pc_s;
  logic [31:0] instr_s;
  logic [3:0]  op_s, rd_s, rs_s, rt_s;
  logic [15:0] imm_s;
  logic [31:0] simm_s;
  logic [31:0] rs_val_s, rt_val_s;
  logic [31:0] pc_plus4_s, br_target_s, pc_next_s;
  logic        wr_en_s, halt_s;
  logic [31:0] wr_data_s;

  calc_pc PC (
    .clk   (clk),
    .reset (reset),
    .en    (~halted & ~halt_s),
    .d     (pc_next_s),
    .q     (pc_s)
  );

  calc_imem #(.DEPTH(IMEM_DEPTH), .AW(AW)) instMem (
    .addr (pc_s[AW+1:2]),
    .data (instr_s)
  );

  calc_regfile regFile (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs_s),
    .rt_addr (rt_s),
    .rs_data (rs_val_s),
    .rt_data (rt_val_s),
    .we      (wr_en_s & ~halted),
    .wr_addr (rd_s),
    .wr_data (wr_data_s)
  );

  assign op_s   = instr_s[31:28];
  assign rd_s   = instr_s[27:24];
  assign rs_s   = instr_s[23:20];
  assign rt_s   = instr_s[19:16];
  assign imm_s  = instr_s[15:0];
  assign simm_s = {{16{imm_s[15]}}, imm_s};

  // Decode/execute: result, write enable and next PC for the current instruction.
  always_comb begin
    pc_plus4_s  = pc_s + 32'd4;
    br_target_s = pc_plus4_s + {simm_s[29:0], 2'b00};
    pc_next_s   = pc_plus4_s;
    wr_en_s     = 1'b0;
    wr_data_s   = 32'd0;
    halt_s      = 1'b0;
    case (op_s)
      OP_ADD:  begin wr_en_s = 1'b1; wr_data_s = rs_val_s + rt_val_s; end
      OP_SUB:  begin wr_en_s = 1'b1; wr_data_s = rs_val_s - rt_val_s; end
      OP_ADDI: begin wr_en_s = 1'b1; wr_data_s = rs_val_s + simm_s; end
`ifdef CALC_MUL_EN
      OP_MUL:  begin wr_en_s = 1'b1; wr_data_s = rs_val_s * rt_val_s; end
`else
      OP_MUL:  begin wr_en_s = 1'b0; end
`endif
      OP_AND:  begin wr_en_s = 1'b1; wr_data_s = rs_val_s & rt_val_s; end
      OP_OR:   begin wr_en_s = 1'b1; wr_data_s = rs_val_s | rt_val_s; end
      OP_XOR:  begin wr_en_s = 1'b1; wr_data_s = rs_val_s ^ rt_val_s; end
      OP_SLL:  begin wr_en_s = 1'b1; wr_data_s = rs_val_s << rt_val_s[4:0]; end
      OP_SRL:  begin wr_en_s = 1'b1; wr_data_s = rs_val_s >> rt_val_s[4:0]; end
      OP_BEQ: begin
        if (rs_val_s == rt_val_s) begin
          pc_next_s = br_target_s;
        end else begin
          pc_next_s = pc_plus4_s;
        end
      end
      OP_BNE: begin
        if (rs_val_s != rt_val_s) begin
          pc_next_s = br_target_s;
        end else begin
          pc_next_s = pc_plus4_s;
        end
      end
      OP_JMP:  begin pc_next_s = {pc_s[31:18], imm_s, 2'b00}; end
      // HALT holds the PC on its own address.
      OP_HALT: begin halt_s = 1'b1; pc_next_s = pc_s; end
      default: begin pc_next_s = pc_plus4_s; end
    endcase
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (halt_s) begin
      halted <= 1'b1;
    end else begin
      halted <= halted;
    end
  end
endmodule

// File: tb/tb_calc.sv
// Directed self-checking bench for calc: loads programs into instMem and checks PC/regs/halted.
module tb_calc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  calc #(.IMEM_DEPTH(1024)) dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [15:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) dut.instMem.mem[i] = 32'd0;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.instMem.mem[idx] = w;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset low for 3 edges, check reset state, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", dut.PC.q, 32'd0);
    chk("rst_halted", {31'd0, dut.halted}, 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("rst_r%0d", i), dut.regFile.regs[i], 32'd0);
    reset = 1'b1;
  endtask

  task automatic load_add();
    clear_mem();
    put(0, enc(4'h3, 4'd1, 4'd0, 4'd0, 16'd5));
    put(1, enc(4'h3, 4'd2, 4'd0, 4'd0, 16'd7));
    put(2, enc(4'h1, 4'd3, 4'd1, 4'd2, 16'd0));
    put(3, enc(4'h2, 4'd4, 4'd1, 4'd2, 16'd0));
    put(4, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
  endtask

  initial begin
    // Reset then NOPs.
    clear_mem();
    do_reset();
    step(2);
    chk("nop_pc", dut.PC.q, 32'h8);

    // Add program with halt.
    load_add();
    do_reset();
    step(5);
    chk("add_r1", dut.regFile.regs[1], 32'd5);
    chk("add_r2", dut.regFile.regs[2], 32'd7);
    chk("add_r3", dut.regFile.regs[3], 32'd12);
    chk("sub_r4", dut.regFile.regs[4], 32'hFFFF_FFFE);
    chk("halt_pc", dut.PC.q, 32'h10);
    chk("halt_flag", {31'd0, dut.halted}, 32'd1);
    step(3);
    chk("halt_pc_frozen", dut.PC.q, 32'h10);
    chk("halt_r3_frozen", dut.regFile.regs[3], 32'd12);

    // Wraparound and r0.
    clear_mem();
    put(0, enc(4'h3, 4'd1, 4'd0, 4'd0, 16'hFFFF));
    put(1, enc(4'h3, 4'd1, 4'd1, 4'd0, 16'd1));
    put(2, enc(4'h3, 4'd0, 4'd0, 4'd0, 16'd9));
    put(3, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
    do_reset();
    step(1);
    chk("addi_neg", dut.regFile.regs[1], 32'hFFFF_FFFF);
    step(1);
    chk("addi_wrap", dut.regFile.regs[1], 32'd0);
    step(1);
    chk("r0_zero", dut.regFile.regs[0], 32'd0);
    chk("r0_pc", dut.PC.q, 32'hC);

    // Branches and jump.
    clear_mem();
    put(0, enc(4'hA, 4'd0, 4'd0, 4'd0, 16'd2));
    put(3, enc(4'hB, 4'd0, 4'd0, 4'd0, 16'd2));
    put(4, enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0010));
    put(16, enc(4'h3, 4'd1, 4'd0, 4'd0, 16'd1));
    put(17, enc(4'hB, 4'd0, 4'd1, 4'd0, 16'd1));
    put(19, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
    do_reset();
    step(1);
    chk("beq_taken", dut.PC.q, 32'hC);
    step(1);
    chk("bne_fall", dut.PC.q, 32'h10);
    step(1);
    chk("jmp_pc", dut.PC.q, 32'h40);
    step(2);
    chk("bne_taken", dut.PC.q, 32'h4C);
    step(1);
    chk("br_halt", {31'd0, dut.halted}, 32'd1);

    // Branch at the last word wraps to word 1.
    clear_mem();
    put(0, enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h03FF));
    put(1023, enc(4'hA, 4'd0, 4'd0, 4'd0, 16'd1));
    put(1, enc(4'h3, 4'd5, 4'd0, 4'd0, 16'h0055));
    put(2, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
    do_reset();
    step(1);
    chk("jmp_last", dut.PC.q, 32'hFFC);
    step(1);
    chk("wrap_pc", dut.PC.q, 32'h1004);
    step(2);
    chk("wrap_r5", dut.regFile.regs[5], 32'h55);
    chk("wrap_halt_pc", dut.PC.q, 32'h1008);

    // MUL, logic ops, shifts and a reserved opcode.
    clear_mem();
    put(0, enc(4'h3, 4'd3, 4'd0, 4'd0, 16'd7));
    put(1, enc(4'h3, 4'd1, 4'd0, 4'd0, 16'd1));
    put(2, enc(4'h3, 4'd6, 4'd0, 4'd0, 16'd16));
    put(3, enc(4'h8, 4'd1, 4'd1, 4'd6, 16'd0));
    put(4, enc(4'h1, 4'd2, 4'd1, 4'd0, 16'd0));
    put(5, enc(4'h4, 4'd3, 4'd1, 4'd2, 16'd0));
    put(6, enc(4'h3, 4'd2, 4'd0, 4'd0, 16'd3));
    put(7, enc(4'h4, 4'd3, 4'd1, 4'd2, 16'd0));
    put(8, enc(4'h9, 4'd7, 4'd1, 4'd6, 16'd0));
    put(9, enc(4'h7, 4'd8, 4'd1, 4'd2, 16'd0));
    put(10, enc(4'h6, 4'd9, 4'd1, 4'd2, 16'd0));
    put(11, enc(4'h5, 4'd10, 4'd1, 4'd2, 16'd0));
    put(12, enc(4'hD, 4'd11, 4'd1, 4'd2, 16'd0));
    put(13, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
    do_reset();
    step(4);
    chk("sll_r1", dut.regFile.regs[1], 32'h0001_0000);
    step(2);
`ifdef CALC_MUL_EN
    chk("mul_wrap", dut.regFile.regs[3], 32'd0);
`else
    chk("mul_off_a", dut.regFile.regs[3], 32'd7);
`endif
    step(2);
`ifdef CALC_MUL_EN
    chk("mul_3", dut.regFile.regs[3], 32'h0003_0000);
`else
    chk("mul_off_b", dut.regFile.regs[3], 32'd7);
`endif
    chk("mul_pc", dut.PC.q, 32'h20);
    step(4);
    chk("srl_r7", dut.regFile.regs[7], 32'd1);
    chk("xor_r8", dut.regFile.regs[8], 32'h0001_0003);
    chk("or_r9", dut.regFile.regs[9], 32'h0001_0003);
    chk("and_r10", dut.regFile.regs[10], 32'd0);
    step(2);
    chk("rsvd_r11", dut.regFile.regs[11], 32'd0);
    chk("rsvd_pc", dut.PC.q, 32'h34);

    // Asynchronous reset between edges mid-program.
    load_add();
    do_reset();
    step(3);
    chk("mid_r3", dut.regFile.regs[3], 32'd12);
    #2 reset = 1'b0;
    #1;
    chk("async_pc", dut.PC.q, 32'd0);
    chk("async_r1", dut.regFile.regs[1], 32'd0);
    chk("async_r3", dut.regFile.regs[3], 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("async_hold_pc", dut.PC.q, 32'd0);
    reset = 1'b1;
    step(1);
    chk("restart_pc", dut.PC.q, 32'h4);
    chk("restart_r1", dut.regFile.regs[1], 32'd5);
    chk("restart_r2", dut.regFile.regs[2], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
